// File: rtl/dds_pkg.sv
// Shared DDS parameters, types and the cosine table formula used by the ROM and the bench.
package dds_pkg;

    localparam int PHASE_BITS       = 24;
    localparam int QUANT_BITS       = 8;
    localparam int SAMPLE_WIDTH     = 16;
    localparam int PARALLEL_SAMPLES = 4;
    localparam int CHANNELS         = 8;

    localparam int LUT_DEPTH   = 2 ** QUANT_BITS;
    localparam int DITHER_BITS = PHASE_BITS - QUANT_BITS;
    localparam int LFSR_BITS   = 16;

    typedef logic [PHASE_BITS-1:0]          phase_t;
    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic [QUANT_BITS-1:0]          lut_addr_t;

    // floor((2**(W-1)-0.5)*cos(2*pi*a/DEPTH) - 0.5), so a=0 gives +full scale and a=DEPTH/2 gives -full scale
    function automatic sample_t lut_value(input int addr);
        real amp;
        real x;
        amp = real'(2 ** (SAMPLE_WIDTH - 1)) - 0.5;
        x   = amp * $cos(2.0 * 3.14159265358979323846 * real'(addr) / real'(LUT_DEPTH)) - 0.5;
        return sample_t'($rtoi($floor(x)));
    endfunction

endpackage

// File: rtl/dds_cos_lut.sv
// Quarter-wave cosine ROM with symmetry folding and a single registered read stage.
module dds_cos_lut
    import dds_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  lut_addr_t addr,
    output sample_t   data
);

    localparam int QUARTER = LUT_DEPTH / 4;
    localparam logic [QUANT_BITS-2:0] QUARTER_IDX = (QUANT_BITS-1)'(QUARTER);

    sample_t rom [0:QUARTER];

    for (genvar i = 0; i <= QUARTER; i++) begin : g_rom
        localparam sample_t ROM_VAL = lut_value(i);
        assign rom[i] = ROM_VAL;
    end

    logic [QUANT_BITS-2:0] idx;
    logic                  negate;
    sample_t               mag;
    sample_t               folded;

    // The floor in the table formula makes the negative half -v-2, except at the exact peak where it is -v-1
    always_comb begin
        idx    = addr[QUANT_BITS-2] ? (QUARTER_IDX - {1'b0, addr[QUANT_BITS-3:0]})
                                    : {1'b0, addr[QUANT_BITS-3:0]};
        negate = addr[QUANT_BITS-1] ^ addr[QUANT_BITS-2];
        mag    = rom[idx];
        folded = mag;
        if (negate) begin
            folded = (idx == '0) ? ~mag : (~mag - sample_t'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else begin
            data <= folded;
        end
    end

endmodule

// File: rtl/dds.sv
// Multi-channel parallel DDS; define DDS_PHASE_DITHER_EN to add per-channel LFSR phase dither.
module dds
    import dds_pkg::*;
(
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            phase_inc_in_valid,
    output logic                                            phase_inc_in_ready,
    input  logic [CHANNELS*PHASE_BITS-1:0]                  phase_inc_in_data,
    output logic                                            data_out_valid,
    output logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_out_data
);

    logic [1:0] rst_sync;
    logic       rst_int;
    logic       handshake;
    logic       load_offsets;
    logic       configured;
    logic       valid_phase;
    logic       valid_lut;

    phase_t    inc_reg   [CHANNELS];
    phase_t    inc_pair  [CHANNELS];
    phase_t    acc       [CHANNELS];
    phase_t    off_next  [CHANNELS][PARALLEL_SAMPLES];
    phase_t    off       [CHANNELS][PARALLEL_SAMPLES];
    phase_t    dither    [CHANNELS][PARALLEL_SAMPLES];
    lut_addr_t addr_q    [CHANNELS][PARALLEL_SAMPLES];
    sample_t   lut_q     [CHANNELS][PARALLEL_SAMPLES];

    // Reset asserts asynchronously everywhere but releases on a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst_int   = rst_sync[1];
    assign handshake = phase_inc_in_valid && phase_inc_in_ready;

    always_comb begin
        phase_t run;
        for (int c = 0; c < CHANNELS; c++) begin
            run = '0;
            for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
                off_next[c][k] = run;
                run            = run + inc_reg[c];
            end
        end
    end

`ifdef DDS_PHASE_DITHER_EN
    logic [LFSR_BITS-1:0] lfsr [CHANNELS];

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            for (int c = 0; c < CHANNELS; c++) begin
                lfsr[c] <= 16'hACE1 + LFSR_BITS'(c);
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                lfsr[c] <= {lfsr[c][LFSR_BITS-2:0],
                            lfsr[c][15] ^ lfsr[c][13] ^ lfsr[c][12] ^ lfsr[c][10]};
            end
        end
    end

    always_comb begin
        logic [LFSR_BITS-1:0] rot;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
                rot          = (lfsr[c] << k) | (lfsr[c] >> (LFSR_BITS - k));
                dither[c][k] = {{(PHASE_BITS-DITHER_BITS){1'b0}}, rot[DITHER_BITS-1:0]};
            end
        end
    end
`else
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
                dither[c][k] = '0;
            end
        end
    end
`endif

    // The accumulator steps with the increment paired to the offsets it is summed with, so updates stay phase continuous
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            phase_inc_in_ready <= 1'b0;
            load_offsets       <= 1'b0;
            configured         <= 1'b0;
            valid_phase        <= 1'b0;
            valid_lut          <= 1'b0;
            data_out_valid     <= 1'b0;
            data_out_data      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                inc_reg[c]  <= '0;
                inc_pair[c] <= '0;
                acc[c]      <= '0;
                for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
                    off[c][k]    <= '0;
                    addr_q[c][k] <= '0;
                end
            end
        end else begin
            phase_inc_in_ready <= 1'b1;
            load_offsets       <= handshake;
            valid_phase        <= configured;
            valid_lut          <= valid_phase;
            data_out_valid     <= valid_lut;
            if (load_offsets) begin
                configured <= 1'b1;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (handshake) begin
                    inc_reg[c] <= phase_inc_in_data[c*PHASE_BITS +: PHASE_BITS];
                end
                if (load_offsets) begin
                    inc_pair[c] <= inc_reg[c];
                    for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
                        off[c][k] <= off_next[c][k];
                    end
                end
                acc[c] <= acc[c] + inc_pair[c] * phase_t'(PARALLEL_SAMPLES);
                for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
                    addr_q[c][k] <= lut_addr_t'((acc[c] + off[c][k] + dither[c][k]) >> DITHER_BITS);
                    data_out_data[(c*PARALLEL_SAMPLES+k)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <=
                        valid_lut ? lut_q[c][k] : '0;
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        for (genvar k = 0; k < PARALLEL_SAMPLES; k++) begin : g_samp
            dds_cos_lut u_lut (
                .clk   (clk),
                .reset (rst_int),
                .addr  (addr_q[c][k]),
                .data  (lut_q[c][k])
            );
        end
    end

endmodule

// File: tb/tb_dds.sv
// Scoreboard bench for dds: a batch-level phase model predicts every output cycle.
module tb_dds;
    import dds_pkg::*;

    localparam int IW = CHANNELS * PHASE_BITS;
    localparam int NS = CHANNELS * PARALLEL_SAMPLES;
    localparam int DW = NS * SAMPLE_WIDTH;
    localparam int LATENCY = 5;

    typedef struct {
        int                       due;
        logic [DW-1:0]            data;
        logic [NS*PHASE_BITS-1:0] ph;
    } sb_item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          phase_inc_in_valid;
    logic          phase_inc_in_ready;
    logic [IW-1:0] phase_inc_in_data;
    logic          data_out_valid;
    logic [DW-1:0] data_out_data;

    dds dut (
        .clk                (clk),
        .reset              (reset),
        .phase_inc_in_valid (phase_inc_in_valid),
        .phase_inc_in_ready (phase_inc_in_ready),
        .phase_inc_in_data  (phase_inc_in_data),
        .data_out_valid     (data_out_valid),
        .data_out_data      (data_out_data)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       cycle  = 0;
    phase_t   m_inc  [CHANNELS];
    phase_t   m_base [CHANNELS];
    bit       m_cfg;
    sb_item_t sb [$];
    logic [IW-1:0] cfg;

    task automatic model_reset();
        sb.delete();
        m_cfg = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            m_inc[c]  = '0;
            m_base[c] = '0;
        end
    endtask

    // Drives one cycle of input and predicts the batch that leaves the DUT LATENCY cycles later
    task automatic applyStimulus(input logic v, input logic [IW-1:0] d);
        sb_item_t item;
        phase_t   p;
        phase_inc_in_valid = v;
        phase_inc_in_data  = d;
        if (v) begin
            m_cfg = 1'b1;
            for (int c = 0; c < CHANNELS; c++) m_inc[c] = d[c*PHASE_BITS +: PHASE_BITS];
        end
        if (m_cfg) begin
            item.due  = cycle + LATENCY;
            item.data = '0;
            item.ph   = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
                    p = m_base[c] + m_inc[c] * phase_t'(k);
                    item.ph[(c*PARALLEL_SAMPLES+k)*PHASE_BITS +: PHASE_BITS] = p;
                    item.data[(c*PARALLEL_SAMPLES+k)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                        lut_value(int'(p[PHASE_BITS-1 -: QUANT_BITS]));
                end
                m_base[c] = m_base[c] + m_inc[c] * phase_t'(PARALLEL_SAMPLES);
            end
            sb.push_back(item);
        end
    endtask

    task automatic checkOutput();
        logic     exp_valid;
        sb_item_t item;
        real      ideal;
        real      err;
        real      max_err;
        phase_t   p;
        sample_t  s;
        exp_valid = (sb.size() > 0) && (sb[0].due == cycle);
        checks++;
        assert (data_out_valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL valid cycle %0d: observed %b expected %b", cycle, data_out_valid, exp_valid);
        end
        if (exp_valid) begin
            item = sb.pop_front();
            checks++;
            assert (data_out_data === item.data) else begin
                errors++;
                $error("[TB] FAIL data cycle %0d: observed %h expected %h", cycle, data_out_data, item.data);
            end
            max_err = 0.0;
            for (int i = 0; i < NS; i++) begin
                p     = item.ph[i*PHASE_BITS +: PHASE_BITS];
                s     = data_out_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                ideal = 32767.5 * $cos(2.0 * 3.14159265358979323846 * real'(p) / real'(2 ** PHASE_BITS));
                err   = real'(s) - ideal;
                if (err < 0.0) err = -err;
                if (err > max_err) max_err = err;
            end
            checks++;
            assert (max_err <= 1024.0) else begin
                errors++;
                $error("[TB] FAIL tolerance cycle %0d: observed error %f expected <= 1024", cycle, max_err);
            end
        end else begin
            checks++;
            assert (data_out_data === '0) else begin
                errors++;
                $error("[TB] FAIL idle_data cycle %0d: observed %h expected 0", cycle, data_out_data);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle++;
        checkOutput();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            applyStimulus(1'b0, '0);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (phase_inc_in_ready !== 1'b1 && n < 10) begin
            step();
            applyStimulus(1'b0, '0);
            n++;
        end
        checks++;
        assert (phase_inc_in_ready === 1'b1) else begin
            errors++;
            $error("[TB] FAIL ready_after_reset: observed %b expected 1", phase_inc_in_ready);
        end
    endtask

    task automatic check_sample(input string tag, input int c, input int k, input sample_t exp);
        sample_t obs;
        obs = data_out_data[(c*PARALLEL_SAMPLES+k)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s ch%0d k%0d: observed %h expected %h", tag, c, k, obs, exp);
        end
    endtask

    initial begin
        reset              = 1'b1;
        phase_inc_in_valid = 1'b0;
        phase_inc_in_data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        assert (phase_inc_in_ready === 1'b0) else begin
            errors++;
            $error("[TB] FAIL reset_ready: observed %b expected 0", phase_inc_in_ready);
        end
        checks++;
        assert (data_out_valid === 1'b0 && data_out_data === '0) else begin
            errors++;
            $error("[TB] FAIL reset_out: observed valid %b data %h expected 0", data_out_valid, data_out_data);
        end
        reset = 1'b0;

        $display("[TB] idle after reset, no configuration");
        wait_ready();
        idle(100);

        $display("[TB] all channels 100 MHz, latency and 512 captured cycles");
        for (int c = 0; c < CHANNELS; c++) cfg[c*PHASE_BITS +: PHASE_BITS] = 24'h040000;
        step();
        applyStimulus(1'b1, cfg);
        for (int i = 1; i < LATENCY; i++) begin
            step();
            applyStimulus(1'b0, '0);
            checks++;
            assert (data_out_valid === 1'b0) else begin
                errors++;
                $error("[TB] FAIL latency_early cycle+%0d: observed %b expected 0", i, data_out_valid);
            end
        end
        step();
        applyStimulus(1'b0, '0);
        checks++;
        assert (data_out_valid === 1'b1) else begin
            errors++;
            $error("[TB] FAIL latency_exact: observed %b expected 1", data_out_valid);
        end
        check_sample("first_batch_100mhz", 0, 0, 16'sh7fff);
        idle(512);

        $display("[TB] per-channel (c+1)*150 MHz");
        for (int c = 0; c < CHANNELS; c++) cfg[c*PHASE_BITS +: PHASE_BITS] = phase_t'((c + 1) * 24'h060000);
        step();
        applyStimulus(1'b1, cfg);
        idle(80);

        $display("[TB] back-to-back 100 MHz then 300 MHz");
        for (int c = 0; c < CHANNELS; c++) cfg[c*PHASE_BITS +: PHASE_BITS] = 24'h040000;
        step();
        applyStimulus(1'b1, cfg);
        for (int c = 0; c < CHANNELS; c++) cfg[c*PHASE_BITS +: PHASE_BITS] = 24'h0c0000;
        step();
        applyStimulus(1'b1, cfg);
        idle(60);

        $display("[TB] reset mid-stream and restart");
        step();
        reset = 1'b1;
        #1;
        checks++;
        assert (data_out_valid === 1'b0 && data_out_data === '0) else begin
            errors++;
            $error("[TB] FAIL reset_async: observed valid %b data %h expected 0", data_out_valid, data_out_data);
        end
        model_reset();
        step();
        reset = 1'b0;
        applyStimulus(1'b0, '0);
        wait_ready();
        idle(3);

        $display("[TB] ch0 inc 0, ch1 Nyquist");
        for (int c = 0; c < CHANNELS; c++) cfg[c*PHASE_BITS +: PHASE_BITS] = 24'h040000;
        cfg[0*PHASE_BITS +: PHASE_BITS] = 24'h000000;
        cfg[1*PHASE_BITS +: PHASE_BITS] = 24'h800000;
        step();
        applyStimulus(1'b1, cfg);
        idle(LATENCY - 1);
        step();
        applyStimulus(1'b0, '0);
        for (int c = 0; c < CHANNELS; c++) check_sample("restart_phase0", c, 0, 16'sh7fff);
        for (int i = 0; i < 8; i++) begin
            step();
            applyStimulus(1'b0, '0);
            for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
                check_sample("ch0_constant", 0, k, 16'sh7fff);
                check_sample("ch1_nyquist", 1, k, (k % 2 == 0) ? 16'sh7fff : 16'sh8000);
            end
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
